// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// requests to instruction memory, buffers returned words with their PC+4 in a
// small prefetch queue and presents the queue head to the IF/ID register.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         Clk,
    input  logic                         Reset,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ready,
    input  logic [31:0]                  imem_rdata,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         id_valid,
    output logic [31:0]                  id_instr,
    output logic [31:0]                  id_pcplus4,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt, addr_nxt, pc_plus4;
    logic            push, pop, flush;
    logic [CW-1:0]   cnt_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [31:0]     q_instr [DEPTH];
    logic [31:0]     q_pcp4  [DEPTH];
    logic [31:0]     head_instr_nxt, head_pcp4_nxt;

    assign pc_plus4 = pc + 32'd4;

    // Next-state, PC, request address and queue bookkeeping
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        addr_nxt       = imem_addr;
        push           = 1'b0;
        flush          = redirect;
        pop            = id_valid && !stall && !redirect;
        cnt_nxt        = q_count;
        rd_nxt         = rd_ptr;
        wr_nxt         = wr_ptr;
        head_instr_nxt = id_instr;
        head_pcp4_nxt  = id_pcplus4;

        unique case (state)
            IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (q_count < CW'(DEPTH)) begin
                    state_nxt = WAIT;
                    addr_nxt  = pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                    if (imem_ready) addr_nxt = redirect_pc;
                    else            state_nxt = DROP;
                end else if (imem_ready) begin
                    push     = 1'b1;
                    pc_nxt   = pc_plus4;
                    addr_nxt = pc_plus4;
                end
            end
            DROP: begin
                if (redirect) pc_nxt = redirect_pc;
                if (imem_ready) begin
                    state_nxt = WAIT;
                    addr_nxt  = pc_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            cnt_nxt = '0;
            rd_nxt  = '0;
            wr_nxt  = '0;
        end else begin
            cnt_nxt = q_count + CW'(push) - CW'(pop);
            rd_nxt  = rd_ptr + PW'(pop);
            wr_nxt  = wr_ptr + PW'(push);
        end

        // Stop issuing once the queue will be full after this cycle
        if (state == WAIT && push && cnt_nxt >= CW'(DEPTH)) state_nxt = IDLE;

        // Head seen by IDLF/ID next cycle; a word written this cycle may become the head
        if (cnt_nxt != '0) begin
            if (push && rd_nxt == wr_ptr) begin
                head_instr_nxt = imem_rdata;
                head_pcp4_nxt  = pc_plus4;
            end else begin
                head_instr_nxt = q_instr[rd_nxt];
                head_pcp4_nxt  = q_pcp4[rd_nxt];
            end
        end
    end

    // Control state and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            id_valid   <= 1'b0;
            id_instr   <= 32'h0;
            id_pcplus4 <= 32'h0;
            q_count    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            imem_req   <= (state_nxt != IDLE);
            imem_addr  <= addr_nxt;
            id_valid   <= (cnt_nxt != '0);
            id_instr   <= head_instr_nxt;
            id_pcplus4 <= head_pcp4_nxt;
            q_count    <= cnt_nxt;
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
        end
    end

    // Queue storage; contents are only meaningful below q_count
    always_ff @(posedge Clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pcp4[wr_ptr]  <= pc_plus4;
        end
    end

endmodule
